// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the k_and_s data path: instruction decode,
// opcode values and ALU operation encodings.
package k_and_s_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_SEL_W = 2;

  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OPC_NOP     = 8'h00;
  localparam logic [7:0] OPC_BRANCH  = 8'h01;
  localparam logic [7:0] OPC_BZERO   = 8'h02;
  localparam logic [7:0] OPC_BNEG    = 8'h03;
  localparam logic [7:0] OPC_BOV     = 8'h04;
  localparam logic [7:0] OPC_BNOV    = 8'h05;
  localparam logic [7:0] OPC_BNNEG   = 8'h0A;
  localparam logic [7:0] OPC_BNZERO  = 8'h0B;
  localparam logic [7:0] OPC_LOAD    = 8'h81;
  localparam logic [7:0] OPC_STORE   = 8'h82;
  localparam logic [7:0] OPC_MOVE    = 8'h91;
  localparam logic [7:0] OPC_ADD     = 8'hA1;
  localparam logic [7:0] OPC_SUB     = 8'hA2;
  localparam logic [7:0] OPC_AND     = 8'hA3;
  localparam logic [7:0] OPC_OR      = 8'hA4;
  localparam logic [7:0] OPC_HALT    = 8'hFF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/data_path_alu.sv
// Combinational 16-bit ALU: result plus next zero/negative/carry/overflow flags.
module alu
  import k_and_s_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              neg_o,
  output logic              uov_o,
  output logic              sov_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra MSB carries the carry-out on add and the borrow on subtract.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    uov_o    = 1'b0;
    sov_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        uov_o    = sum[DATA_W];
        sov_o    = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                   (result_o[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_SUB: begin
        result_o = diff[DATA_W-1:0];
        uov_o    = diff[DATA_W];
        sov_o    = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                   (result_o[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      default: result_o = a_i | b_i;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign neg_o  = result_o[DATA_W-1];

endmodule

// File: rtl/data_path.sv
// k_and_s data path: PC, IR, instruction decoder, 4x16 register file,
// flag register and the ALU instance, steered by the control strobes.
module data_path
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]    ir_q, ir_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic                 zero_q, zero_d, neg_q, neg_d;
  logic                 uov_q, uov_d, sov_q, sov_d;

  logic [REG_SEL_W-1:0] rd_sel, ra_sel;
  logic [DATA_W-1:0]    alu_b, alu_result, wb_data;
  logic                 alu_zero, alu_neg, alu_uov, alu_sov;
  logic                 unused_ir_bit;

  assign unused_ir_bit = ir_q[7];

  always_comb begin
    case (ir_q[15:8])
      OPC_NOP:    decoded_instruction = I_NOP;
      OPC_BRANCH: decoded_instruction = I_BRANCH;
      OPC_BZERO:  decoded_instruction = I_BZERO;
      OPC_BNEG:   decoded_instruction = I_BNEG;
      OPC_BOV:    decoded_instruction = I_BOV;
      OPC_BNOV:   decoded_instruction = I_BNOV;
      OPC_BNNEG:  decoded_instruction = I_BNNEG;
      OPC_BNZERO: decoded_instruction = I_BNZERO;
      OPC_LOAD:   decoded_instruction = I_LOAD;
      OPC_STORE:  decoded_instruction = I_STORE;
      OPC_MOVE:   decoded_instruction = I_MOVE;
      OPC_ADD:    decoded_instruction = I_ADD;
      OPC_SUB:    decoded_instruction = I_SUB;
      OPC_AND:    decoded_instruction = I_AND;
      OPC_OR:     decoded_instruction = I_OR;
      OPC_HALT:   decoded_instruction = I_HALT;
      default:    decoded_instruction = I_NOP;
    endcase
  end

  // Register-field selection depends on the instruction format.
  always_comb begin
    rd_sel = ir_q[5:4];
    ra_sel = ir_q[3:2];
    case (decoded_instruction)
      I_LOAD, I_STORE: rd_sel = ir_q[6:5];
      I_MOVE: begin
        rd_sel = ir_q[3:2];
        ra_sel = ir_q[1:0];
      end
      default: ;
    endcase
  end

  assign alu_b   = (decoded_instruction == I_MOVE) ? '0 : regs_q[ir_q[1:0]];
  assign wb_data = c_sel ? data_in : alu_result;

  alu u_alu (
    .a_i      (regs_q[ra_sel]),
    .b_i      (alu_b),
    .op_i     (operation),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .neg_o    (alu_neg),
    .uov_o    (alu_uov),
    .sov_o    (alu_sov)
  );

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    regs_d = regs_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    uov_d  = uov_q;
    sov_d  = sov_q;
    if (pc_enable) pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    if (ir_enable) ir_d = data_in;
    if (write_reg_enable) regs_d[rd_sel] = wb_data;
    if (flags_reg_enable) begin
      zero_d = alu_zero;
      neg_d  = alu_neg;
      uov_d  = alu_uov;
      sov_d  = alu_sov;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ir_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      regs_q <= regs_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      uov_q  <= uov_d;
      sov_q  <= sov_d;
    end
  end

  assign zero_op           = zero_q;
  assign neg_op            = neg_q;
  assign unsigned_overflow = uov_q;
  assign signed_overflow   = sov_q;
  assign ram_addr          = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
  assign data_out          = regs_q[ir_q[6:5]];

endmodule
